// File: rtl/lowampa_trig_pkg.sv
// Shared types for the low-amplitude trigger collection stage.
package lowampa_trig_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    PRESENT,
    HOLDOFF
  } trig_state_e;

  localparam int unsigned DEF_NBEAMS    = 54;
  localparam int unsigned DEF_TIME_BITS = 32;

  // Trigger record at the default geometry; the top builds the same layout from its parameters.
  typedef struct packed {
    logic [DEF_NBEAMS-1:0]    mask;
    logic [DEF_TIME_BITS-1:0] ts;
  } trig_rec_t;

endpackage

// File: rtl/lowampa_trig_collect_beam_stretch.sv
// Single-beam rising-edge detector and pulse stretcher feeding the scalers.
module beam_stretch #(
  parameter int unsigned STRETCH = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic trig,
  output logic rise,
  output logic stretch
);

  localparam int unsigned CW = $clog2(STRETCH + 1);

  logic          trig_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign rise = trig & ~trig_q;

  always_comb begin
    cnt_nxt = cnt;
    if (rise) begin
      cnt_nxt = CW'(STRETCH);
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // trig_q resets high so a line already asserted at release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      trig_q  <= 1'b1;
      cnt     <= '0;
      stretch <= 1'b0;
    end else begin
      trig_q  <= trig;
      cnt     <= cnt_nxt;
      stretch <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/lowampa_trig_collect.sv
// Collects per-beam trigger edges into timestamped records with holdoff and drop counting.
module lowampa_trig_collect
  import lowampa_trig_pkg::*;
#(
  parameter int unsigned NBEAMS     = 54,
  parameter int unsigned STRETCH    = 8,
  parameter int unsigned GATHER_LEN = 4,
  parameter int unsigned TIME_BITS  = 32,
  parameter int unsigned HOLD_BITS  = 16,
  parameter int unsigned DROP_BITS  = 16
) (
  input  logic                 tclk,
  input  logic                 tclk_resetn,
  input  logic [NBEAMS-1:0]    trig_i,
  input  logic [NBEAMS-1:0]    beam_mask_i,
  input  logic                 enable_i,
  input  logic [HOLD_BITS-1:0] holdoff_i,
  output logic [NBEAMS-1:0]    trig_stretch_o,
  output logic                 rec_valid_o,
  input  logic                 rec_ready_i,
  output logic [NBEAMS-1:0]    rec_mask_o,
  output logic [TIME_BITS-1:0] rec_time_o,
  output logic [DROP_BITS-1:0] dropped_o,
  input  logic                 dropped_clr_i
);

  localparam int unsigned GW = (GATHER_LEN > 1) ? $clog2(GATHER_LEN) : 1;

  logic [NBEAMS-1:0]    rise;
  logic [NBEAMS-1:0]    medge;
  logic                 any_medge;
  logic                 drop;
  trig_state_e          state;
  logic [TIME_BITS-1:0] tcnt;
  logic [GW-1:0]        gcnt;
  logic [HOLD_BITS-1:0] hcnt;

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    beam_stretch #(
      .STRETCH(STRETCH)
    ) u_stretch (
      .clk    (tclk),
      .resetn (tclk_resetn),
      .trig   (trig_i[b]),
      .rise   (rise[b]),
      .stretch(trig_stretch_o[b])
    );
  end

  assign medge     = rise & beam_mask_i;
  assign any_medge = |medge;

  // GATHER absorbs edges into the record, so only busy or disabled cycles lose triggers.
  assign drop = any_medge &&
                ((state == PRESENT) || (state == HOLDOFF) ||
                 ((state == IDLE) && !enable_i));

  always_ff @(posedge tclk) begin
    if (!tclk_resetn) begin
      state       <= IDLE;
      tcnt        <= '0;
      gcnt        <= '0;
      hcnt        <= '0;
      rec_valid_o <= 1'b0;
      rec_mask_o  <= '0;
      rec_time_o  <= '0;
      dropped_o   <= '0;
    end else begin
      tcnt <= tcnt + TIME_BITS'(1);

      if (dropped_clr_i) begin
        dropped_o <= drop ? DROP_BITS'(1) : '0;
      end else if (drop && (dropped_o != '1)) begin
        dropped_o <= dropped_o + DROP_BITS'(1);
      end

      case (state)
        IDLE: begin
          if (enable_i && any_medge) begin
            rec_time_o <= tcnt;
            rec_mask_o <= medge;
            if (GATHER_LEN == 1) begin
              state       <= PRESENT;
              rec_valid_o <= 1'b1;
            end else begin
              gcnt  <= GW'(GATHER_LEN - 1);
              state <= GATHER;
            end
          end
        end
        GATHER: begin
          rec_mask_o <= rec_mask_o | medge;
          gcnt       <= gcnt - GW'(1);
          if (gcnt == GW'(1)) begin
            state       <= PRESENT;
            rec_valid_o <= 1'b1;
          end
        end
        PRESENT: begin
          if (rec_ready_i) begin
            rec_valid_o <= 1'b0;
            if (holdoff_i == '0) begin
              state <= IDLE;
            end else begin
              hcnt  <= holdoff_i;
              state <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          hcnt <= hcnt - HOLD_BITS'(1);
          if (hcnt == HOLD_BITS'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
